keypad_ctrl: RTL

- Sequencing controller for the 16-key front-panel keypad.
- Debounces the raw key lines and detects each new press.
- Encodes the press to a 4-bit key code using the same priority rule as the combinational key encoder: the highest-numbered pressed key wins.
- Queues codes in a small FIFO and hands them to the CPU-side consumer through a valid/ready handshake, so no press is lost while the consumer is busy.

---
 rtl/keypad_ctrl.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/keypad_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : keypad_ctrl
// Purpose  : Sequencing controller for a 16-key front-panel keypad. It
//            debounces the raw key lines and detects each new press. Each
//            press is encoded to a 4-bit code, with the highest-numbered
//            pressed key taking priority. Codes are queued in a small FIFO and
//            handed to the consumer over a valid/ready handshake.
// Ports    : clock      - system clock, rising edge
//            reset      - synchronous, active-high reset
//            keys       - raw key lines (1 = pressed), already synchronised
//            key_code   - FIFO head code, meaningful while key_valid = 1
//            key_valid  - FIFO not empty
//            key_ready  - consumer takes key_code when key_valid & key_ready
//            key_held   - debounced "some key is down"
//            fifo_count - number of queued codes
//            overflow   - sticky, a code was dropped on a full FIFO
//            ovf_clr    - clears overflow (a same-cycle drop wins)
// Options  : define KEYPAD_CTRL_REPEAT_EN to enable auto-repeat while held
//            (first repeat after REP_FIRST cycles, then every REP_NEXT).
// Revision : 1.0 - initial release
// ============================================================================
module keypad_ctrl #(
  parameter int DEB_CYCLES = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int REP_FIRST  = 1024,
  parameter int REP_NEXT   = 256
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [15:0]                   keys,
  output logic [3:0]                    key_code,
  output logic                          key_valid,
  input  logic                          key_ready,
  output logic                          key_held,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          ovf_clr
);

  localparam int CNT_W  = $clog2(DEB_CYCLES);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]  C_DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [FCNT_W-1:0] C_FULL     = FCNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  state_t             r_state;
  logic [15:0]        r_snap;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_held;

  logic [3:0]         r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [FCNT_W-1:0]  r_count;
  logic               r_ovf;

  logic               w_accept;
  logic               w_rep_fire;
  logic               w_push;
  logic [3:0]         w_code;
  logic               w_full;
  logic               w_pop;
  logic               w_wr;
  logic               w_drop;

  // Highest set bit wins.
  function automatic logic [3:0] enc(input logic [15:0] s);
    logic [3:0] code;
    code = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (s[i]) code = 4'(i);
    end
    return code;
  endfunction

  // keys == r_snap implies keys != 0, since the snapshot is never zero here.
  assign w_accept = (r_state == ST_DEBOUNCE) && (keys == r_snap) && (r_cnt == C_DEB_LAST);

  // The snapshot equals keys on the accept cycle and holds the accepted set
  // afterwards, so both press and repeat codes come from it.
  assign w_code = enc(r_snap);
  assign w_push = w_accept | w_rep_fire;

  // --------------------------------------------------------------------------
  // Press/release sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_snap  <= 16'd0;
      r_cnt   <= '0;
      r_held  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (keys != 16'd0) begin
            r_snap  <= keys;
            r_cnt   <= '0;
            r_state <= ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          if (keys == 16'd0) begin
            r_state <= ST_IDLE;
          end else if (keys != r_snap) begin
            r_snap <= keys;
            r_cnt  <= '0;
          end else if (r_cnt == C_DEB_LAST) begin
            r_state <= ST_HELD;
            r_held  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_HELD: begin
          // Changes to the key set while held are ignored (no rollover).
          if (keys == 16'd0) begin
            r_cnt   <= '0;
            r_state <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (keys != 16'd0) begin
            r_state <= ST_HELD;
          end else if (r_cnt == C_DEB_LAST) begin
            r_state <= ST_IDLE;
            r_held  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_held  <= 1'b0;
        end
      endcase
    end
  end

  assign key_held = r_held;

  // --------------------------------------------------------------------------
  // Auto-repeat
  // --------------------------------------------------------------------------
`ifdef KEYPAD_CTRL_REPEAT_EN
  localparam int REP_MAX = (REP_FIRST > REP_NEXT) ? REP_FIRST : REP_NEXT;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] r_rep_cnt;
  logic             r_rep_first;
  logic             w_rep_run;

  // Counting only happens while the key is actually down in HELD; the cycle
  // that sees the release edge already behaves like RELEASE (frozen).
  assign w_rep_run  = (r_state == ST_HELD) && (keys != 16'd0);
  assign w_rep_fire = w_rep_run &&
                      (r_rep_first ? (r_rep_cnt == REP_W'(REP_FIRST - 1))
                                   : (r_rep_cnt == REP_W'(REP_NEXT - 1)));

  always_ff @(posedge clock) begin
    if (reset || r_state == ST_IDLE || w_accept) begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b1;
    end else if (w_rep_fire) begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b0;
    end else if (w_rep_run) begin
      r_rep_cnt <= r_rep_cnt + 1'b1;
    end
  end
`else
  assign w_rep_fire = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Key-code FIFO. Pop is resolved first, so a push onto a full FIFO with a
  // simultaneous pop is accepted.
  // --------------------------------------------------------------------------
  assign w_full = (r_count == C_FULL);
  assign w_pop  = (r_count != '0) && key_ready;
  assign w_wr   = w_push && (!w_full || w_pop);
  assign w_drop = w_push && w_full && !w_pop;

  always_ff @(posedge clock) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= w_code;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= r_count + FCNT_W'(w_wr) - FCNT_W'(w_pop);
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign key_valid  = (r_count != '0);
  assign key_code   = key_valid ? r_mem[r_rd_ptr] : 4'd0;
  assign fifo_count = r_count;
  assign overflow   = r_ovf;

endmodule
`default_nettype wire
